// File: rtl/jeff_74x181.sv
// One 4-bit 74181-style ALU slice, active-high data.
// Carry-in and carry-out are active-high; aeqb is high when f is all ones.
module jeff_74x181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       ci,
  output logic [3:0] f,
  output logic       co,
  output logic       aeqb
);

  logic [3:0] p;
  logic [3:0] q;
  logic [4:0] sum;

  // The arithmetic result is p + q + ci.
  // Logic mode is the carry-free bitwise view of p and q.
  always_comb begin
    p    = a | ({4{s[0]}} & b) | ({4{s[1]}} & ~b);
    q    = ({4{s[3]}} & a & b) | ({4{s[2]}} & a & ~b);
    sum  = {1'b0, p} + {1'b0, q} + {4'b0000, ci};
    f    = m ? ~(p ^ q) : sum[3:0];
    co   = sum[4];
    aeqb = &f;
  end

endmodule

// File: rtl/alu181_bar_seq.sv
// Bit-serial-by-slice 74181 ALU with active-low operands and result.
// One 4-bit slice is computed per RUN cycle, rippling carry through a register.
module alu181_bar_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_BAR,
  input  logic             START,
  input  logic [WIDTH-1:0] A_BAR,
  input  logic [WIDTH-1:0] B_BAR,
  input  logic [3:0]       S,
  input  logic             M,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] F_BAR,
  output logic             CO,
  output logic             AEQB
);

  localparam int SLICES = WIDTH / 4;
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             c_q;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] f_acc;
  logic             eq_acc;

  logic [3:0]       a_s;
  logic [3:0]       b_s;
  logic [3:0]       f_s;
  logic             co_s;
  logic             eq_s;
  logic [WIDTH-1:0] f_nxt;

  assign a_s = a_q[{idx, 2'b00} +: 4];
  assign b_s = b_q[{idx, 2'b00} +: 4];

  jeff_74x181 u_slice (
    .a    (a_s),
    .b    (b_s),
    .s    (s_q),
    .m    (m_q),
    .ci   (c_q),
    .f    (f_s),
    .co   (co_s),
    .aeqb (eq_s)
  );

  // Full result including the slice being finished this cycle.
  always_comb begin
    f_nxt = f_acc;
    f_nxt[{idx, 2'b00} +: 4] = f_s;
  end

  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      m_q    <= 1'b0;
      c_q    <= 1'b0;
      idx    <= '0;
      f_acc  <= '0;
      eq_acc <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      F_BAR  <= '1;
      CO     <= 1'b0;
      AEQB   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            a_q    <= ~A_BAR;
            b_q    <= ~B_BAR;
            s_q    <= S;
            m_q    <= M;
            c_q    <= CI;
            idx    <= '0;
            f_acc  <= '0;
            eq_acc <= 1'b1;
            BUSY   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          f_acc  <= f_nxt;
          c_q    <= co_s;
          eq_acc <= eq_acc & eq_s;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            F_BAR <= ~f_nxt;
            CO    <= co_s;
            AEQB  <= eq_acc & eq_s;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu181_bar_seq.sv
// Scoreboard bench for alu181_bar_seq at WIDTH=16.
// Expected results come from a full-width 74181 function-table model.
module tb_alu181_bar_seq;

  localparam int W = 16;
  localparam int SL = W / 4;

  logic         CLK;
  logic         RST_BAR;
  logic         START;
  logic [W-1:0] A_BAR;
  logic [W-1:0] B_BAR;
  logic [3:0]   S;
  logic         M;
  logic         CI;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] F_BAR;
  logic         CO;
  logic         AEQB;

  alu181_bar_seq #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RST_BAR (RST_BAR),
    .START   (START),
    .A_BAR   (A_BAR),
    .B_BAR   (B_BAR),
    .S       (S),
    .M       (M),
    .CI      (CI),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .F_BAR   (F_BAR),
    .CO      (CO),
    .AEQB    (AEQB)
  );

  typedef struct {
    logic [W-1:0] f_bar;
    logic         co;
    logic         aeqb;
    int           issue;
  } exp_t;

  exp_t         sb[$];
  int           tests;
  int           fails;
  int           cyc;
  logic [W-1:0] hold_f;
  logic         hold_co;
  logic         hold_eq;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the 74181 table applied to whole words.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] s, input logic m,
                                 input logic ci);
    logic [W:0]   x;
    logic [W:0]   y;
    logic [W:0]   sum;
    logic [W-1:0] lg;
    logic [W-1:0] nb;
    logic [W-1:0] ones;
    exp_t         r;
    ones = '1;
    nb   = ~b;
    x    = '0;
    y    = '0;
    lg   = '0;
    case (s)
      4'd0:  begin x = a;        y = '0;          lg = ~a;       end
      4'd1:  begin x = a | b;    y = '0;          lg = ~(a | b); end
      4'd2:  begin x = a | nb;   y = '0;          lg = ~a & b;   end
      4'd3:  begin x = ones;     y = '0;          lg = '0;       end
      4'd4:  begin x = a;        y = a & nb;      lg = ~(a & b); end
      4'd5:  begin x = a | b;    y = a & nb;      lg = nb;       end
      4'd6:  begin x = a;        y = nb;          lg = a ^ b;    end
      4'd7:  begin x = a & nb;   y = ones;        lg = a & nb;   end
      4'd8:  begin x = a;        y = a & b;       lg = ~a | b;   end
      4'd9:  begin x = a;        y = b;           lg = ~(a ^ b); end
      4'd10: begin x = a | nb;   y = a & b;       lg = b;        end
      4'd11: begin x = a & b;    y = ones;        lg = a & b;    end
      4'd12: begin x = a;        y = a;           lg = ones;     end
      4'd13: begin x = a | b;    y = a;           lg = a | nb;   end
      4'd14: begin x = a | nb;   y = a;           lg = a | b;    end
      default: begin x = a;      y = ones;        lg = a;        end
    endcase
    sum     = x + y + {{W{1'b0}}, ci};
    r.f_bar = m ? ~lg : ~sum[W-1:0];
    r.co    = sum[W];
    r.aeqb  = m ? (lg == ones) : (sum[W-1:0] == ones);
    r.issue = 0;
    return r;
  endfunction

  // Monitor: pops on DONE, otherwise outputs must hold the last result.
  always @(negedge CLK) begin
    if (RST_BAR) begin
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(DONE), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("f_bar", 64'(F_BAR), 64'(e.f_bar));
          chk("co", 64'(CO), 64'(e.co));
          chk("aeqb", 64'(AEQB), 64'(e.aeqb));
          chk("latency", 64'(cyc - e.issue), 64'(SL + 1));
          chk("busy_in_fin", 64'(BUSY), 64'(1));
          hold_f  = e.f_bar;
          hold_co = e.co;
          hold_eq = e.aeqb;
        end
      end else begin
        chk("hold_f", 64'(F_BAR), 64'(hold_f));
        chk("hold_co", 64'(CO), 64'(hold_co));
        chk("hold_eq", 64'(AEQB), 64'(hold_eq));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY) chk("idle_timeout", 64'(BUSY), 64'(0));
  endtask

  task automatic issue(input logic [W-1:0] ab, input logic [W-1:0] bb,
                       input logic [3:0] s, input logic m, input logic ci,
                       input bit push, input bit lit,
                       input logic [W-1:0] ef, input logic ec,
                       input logic ee);
    exp_t e;
    wait_idle();
    START = 1'b1;
    A_BAR = ab;
    B_BAR = bb;
    S     = s;
    M     = m;
    CI    = ci;
    e = model(~ab, ~bb, s, m, ci);
    if (lit) begin
      e.f_bar = ef;
      e.co    = ec;
      e.aeqb  = ee;
    end
    e.issue = cyc;
    if (push) sb.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    A_BAR = W'($urandom);
    B_BAR = W'($urandom);
    S     = 4'($urandom);
    M     = 1'($urandom);
    CI    = 1'($urandom);
    chk("busy_after_start", 64'(BUSY), 64'(1));
  endtask

  initial begin
    int n;
    tests   = 0;
    fails   = 0;
    cyc     = 0;
    hold_f  = '1;
    hold_co = 1'b0;
    hold_eq = 1'b0;
    RST_BAR = 1'b0;
    START   = 1'b0;
    A_BAR   = '0;
    B_BAR   = '0;
    S       = '0;
    M       = 1'b0;
    CI      = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_f_bar", 64'(F_BAR), 64'(16'hFFFF));
    chk("rst_co", 64'(CO), 64'(0));
    chk("rst_aeqb", 64'(AEQB), 64'(0));
    RST_BAR = 1'b1;

    issue(16'hEDCB, 16'hF000, 4'b1001, 1'b0, 1'b0, 1, 1, 16'hDDCC, 0, 0);
    issue(16'h0000, 16'hFFFE, 4'b1001, 1'b0, 1'b0, 1, 1, 16'hFFFF, 1, 0);
    issue(16'hA5A5, 16'hA5A5, 4'b0110, 1'b0, 1'b0, 1, 1, 16'h0000, 0, 1);
    issue(16'h0F0F, 16'h00FF, 4'b0110, 1'b1, 1'b0, 1, 1, 16'hF00F, 0, 0);

    // START pulses while busy must be dropped.
    issue(16'h1234, 16'h8765, 4'b1001, 1'b0, 1'b1, 1, 0, '0, 0, 0);
    START = 1'b1;
    A_BAR = 16'h0000;
    @(negedge CLK);
    START = 1'b0;

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 1, 0, '0, 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        if (BUSY) begin
          START = 1'b1;
          @(negedge CLK);
          START = 1'b0;
        end
      end
    end

    // Abort in RUN: no DONE, outputs back to reset values.
    issue(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0, 0, 0, '0, 0, 0);
    @(negedge CLK);
    RST_BAR = 1'b0;
    #1;
    chk("abort_busy", 64'(BUSY), 64'(0));
    chk("abort_done", 64'(DONE), 64'(0));
    chk("abort_f_bar", 64'(F_BAR), 64'(16'hFFFF));
    chk("abort_co", 64'(CO), 64'(0));
    hold_f  = '1;
    hold_co = 1'b0;
    hold_eq = 1'b0;
    @(negedge CLK);
    RST_BAR = 1'b1;
    issue(16'h5555, 16'h3333, 4'b0110, 1'b1, 1'b0, 1, 0, '0, 0, 0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
    repeat (4) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
